// File: rtl/mem_responder.sv
// Single-port word memory answering processor reads after READ_LAT cycles and writes in one cycle.
// While a read is in flight Busy is high and any request is dropped with a one-cycle Err pulse.
module mem_responder #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        DValid,
    output logic        Busy,
    output logic        Err,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        RWAIT
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        done;

    logic [15:0] mem [DEPTH];
    logic [15:0] rd_data;
    logic [15:0] rd_samp;
    logic [15:0] ret_data;

    logic        in_range;
    logic        rd_ok;
    logic        wr_ok;
    logic        err_nxt;

    // Compare in 17 bits so DEPTH=65536 is handled without overflow
    assign in_range = ({1'b0, Addr} < 17'(DEPTH));
    assign Busy     = (state == RWAIT);
    assign rd_ok    = !Busy && RD && !WR;
    assign wr_ok    = !Busy && WR && !RD;
    assign err_nxt  = (Busy && (RD || WR))
                   || (!Busy && RD && WR)
                   || ((rd_ok || wr_ok) && !in_range);

    assign rd_data  = in_range ? mem[Addr[AW-1:0]] : 16'h0000;
    assign ret_data = (READ_LAT == 1) ? rd_data : rd_samp;

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (rd_ok) begin
                    if (READ_LAT == 1) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = RWAIT;
                        cnt_nxt   = 3'(READ_LAT - 1);
                    end
                end
            end
            RWAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            DataOut <= 16'h0000;
            DValid  <= 1'b0;
            Err     <= 1'b0;
            RdCount <= 16'h0000;
            WrCount <= 16'h0000;
            rd_samp <= 16'h0000;
        end else begin
            DValid <= done;
            Err    <= err_nxt;
            if (rd_ok) begin
                rd_samp <= rd_data;
            end
            if (done) begin
                DataOut <= ret_data;
                if (RdCount != 16'hFFFF) begin
                    RdCount <= RdCount + 16'd1;
                end
            end
            if (wr_ok && in_range && (WrCount != 16'hFFFF)) begin
                WrCount <= WrCount + 16'd1;
            end
        end
    end

    // Array is deliberately left out of reset; writes are held off while Reset is high
    always_ff @(posedge Clk1) begin
        if (!Reset && wr_ok && in_range) begin
            mem[Addr[AW-1:0]] <= DataIn;
        end
    end

endmodule
